// File: rtl/btn_event_decoder.sv
// -----------------------------------------------------------------------------
// btn_event_decoder
//
// Classifies the debounced press/release events of a single button into
// click, double-click, long-press and auto-repeat gestures. Time is measured
// in sample_ce ticks (shared 1 kHz timebase from ce_gen). Each gesture event
// is reported as a registered, one-clock pulse.
//
// Parameters
//   CE_HZ      rate of sample_ce in Hz
//   LONG_MS    hold time that declares a long press
//   DBL_MS     window after a short release for a second press (double-click)
//   REPEAT_MS  auto-repeat period while a long press is held
//   EN_DOUBLE  1: double-click detection on; 0: click reported on release
//   The derived tick counts (rounded up) must each be at least 2.
//
// Ports
//   clk              system clock (single clock domain)
//   rst_n            asynchronous active-low reset
//   sample_ce        one-clock timebase tick
//   press_pulse      one-clock debounced press event
//   release_pulse    one-clock debounced release event
//   click_pulse      single short click
//   dbl_click_pulse  double-click
//   long_pulse       long press detected
//   repeat_pulse     auto-repeat tick during a long hold
//   long_active      level, high while the long press is held
// -----------------------------------------------------------------------------
module btn_event_decoder #(
   parameter int CE_HZ     = 1000,
   parameter int LONG_MS   = 800,
   parameter int DBL_MS    = 250,
   parameter int REPEAT_MS = 100,
   parameter bit EN_DOUBLE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_ce,
   input  logic press_pulse,
   input  logic release_pulse,
   output logic click_pulse,
   output logic dbl_click_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic long_active
);

   // Durations in ticks, rounded up so a gesture is never shorter than asked.
   localparam int LONG_T   = (LONG_MS   * CE_HZ + 999) / 1000;
   localparam int DBL_T    = (DBL_MS    * CE_HZ + 999) / 1000;
   localparam int REPEAT_T = (REPEAT_MS * CE_HZ + 999) / 1000;

   localparam int MAX_LD   = (LONG_T > DBL_T) ? LONG_T : DBL_T;
   localparam int MAX_T    = (MAX_LD > REPEAT_T) ? MAX_LD : REPEAT_T;
   localparam int CNT_W    = $clog2(MAX_T + 1);

   // Terminal counts: the Nth tick after entry is seen while the count is N-1.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_T - 1);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_T - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_T - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS1,
      S_WAIT2,
      S_HOLD2,
      S_LONG
   } state_t;

   typedef enum logic [2:0] {
      EV_NONE,
      EV_CLICK,
      EV_DBL,
      EV_LONG,
      EV_REPEAT
   } event_t;

   state_t            state, state_next;
   event_t            ev_next;
   logic              cnt_clr;
   logic [CNT_W-1:0]  cnt;

   logic              click_d, dbl_d, long_d, repeat_d, long_active_d;

   // Press and release together is a protocol violation: both are dropped,
   // leaving only the tick to be processed.
   logic press_ev, release_ev;
   assign press_ev   = press_pulse   & ~release_pulse;
   assign release_ev = release_pulse & ~press_pulse;

   // --------------------------------------------------------------------------
   // State register, shared tick counter and registered outputs
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cnt             <= '0;
         click_pulse     <= 1'b0;
         dbl_click_pulse <= 1'b0;
         long_pulse      <= 1'b0;
         repeat_pulse    <= 1'b0;
         long_active     <= 1'b0;
      end else begin
         state <= state_next;

         // A transition (or a repeat period rollover) wins over a coincident
         // tick: the count restarts at zero and that tick is not counted.
         if ((state_next != state) || cnt_clr) begin
            cnt <= '0;
         end else if (sample_ce && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
         end

         click_pulse     <= click_d;
         dbl_click_pulse <= dbl_d;
         long_pulse      <= long_d;
         repeat_pulse    <= repeat_d;
         long_active     <= long_active_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      ev_next    = EV_NONE;
      cnt_clr    = 1'b0;

      case (state)
         S_IDLE: begin
            if (press_ev) state_next = S_PRESS1;
         end

         S_PRESS1: begin
            if (release_ev) begin
               if (EN_DOUBLE) begin
                  state_next = S_WAIT2;
               end else begin
                  state_next = S_IDLE;
                  ev_next    = EV_CLICK;
               end
            end else if (sample_ce && (cnt == LONG_LAST)) begin
               state_next = S_LONG;
               ev_next    = EV_LONG;
            end
         end

         S_WAIT2: begin
            if (press_ev) begin
               state_next = S_HOLD2;
               ev_next    = EV_DBL;
            end else if (sample_ce && (cnt == DBL_LAST)) begin
               state_next = S_IDLE;
               ev_next    = EV_CLICK;
            end
         end

         // Second press of a double-click: held time is deliberately ignored.
         S_HOLD2: begin
            if (release_ev) state_next = S_IDLE;
         end

         S_LONG: begin
            if (release_ev) begin
               state_next = S_IDLE;
            end else if (sample_ce && (cnt == REP_LAST)) begin
               ev_next = EV_REPEAT;
               cnt_clr = 1'b1;
            end
         end

         default: state_next = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Output decode (feeds the output registers, so at most one pulse per clk)
   // --------------------------------------------------------------------------
   always_comb begin
      click_d       = 1'b0;
      dbl_d         = 1'b0;
      long_d        = 1'b0;
      repeat_d      = 1'b0;
      long_active_d = (state_next == S_LONG);

      case (ev_next)
         EV_CLICK:  click_d  = 1'b1;
         EV_DBL:    dbl_d    = 1'b1;
         EV_LONG:   long_d   = 1'b1;
         EV_REPEAT: repeat_d = 1'b1;
         default:   ;
      endcase
   end

endmodule

// File: doc/btn_event_decoder.md
# btn_event_decoder

Consumes the debounced one-clock `press_pulse` / `release_pulse` events of one button and classifies each gesture as click, double-click, long-press or auto-repeat, emitting one-clock event pulses. The block sits downstream of the button debouncer and shares its 1 kHz `sample_ce` timebase from `ce_gen`. The whole design stays in a single clock domain.

## Interface
- `CE_HZ`, 1000: rate of `sample_ce`.
- `LONG_MS`, 800: hold time that declares a long press.
- `DBL_MS`, 250: window after a short release in which a second press counts as a double-click.
- `REPEAT_MS`, 100: auto-repeat period while a long press is held.
- `EN_DOUBLE`, 1: 1 enables double-click detection; 0 emits a click immediately on release.

- `clk` input 1: system clock, single clock domain.
- `rst_n` input 1: asynchronous active-low reset.
- `sample_ce` input 1: one-clock timebase tick at `CE_HZ`.
- `press_pulse` input 1: one-clock debounced press event.
- `release_pulse` input 1: one-clock debounced release event.
- `click_pulse` output 1: single short click.
- `dbl_click_pulse` output 1: double-click.
- `long_pulse` output 1: long press detected.
- `repeat_pulse` output 1: auto-repeat tick during a long hold.
- `long_active` output 1: level, high while in state LONG.

## Operation
- Tick counts are rounded up:
  - LONG_T = (LONG_MS*CE_HZ+999)/1000
  - DBL_T = (DBL_MS*CE_HZ+999)/1000
  - REPEAT_T = (REPEAT_MS*CE_HZ+999)/1000
  - All three must be at least 2.
- One shared tick counter, width $clog2(max(LONG_T,DBL_T,REPEAT_T)+1). It increments only on `sample_ce`, saturates, and clears on every state change.
- FSM states: IDLE, PRESS1, WAIT2, HOLD2, LONG.
- IDLE:
  - `press_pulse` -> PRESS1.
- PRESS1:
  - `release_pulse`: if `EN_DOUBLE`=1 -> WAIT2; else -> IDLE and emit `click_pulse`.
  - `sample_ce` with count = LONG_T-1 -> LONG and emit `long_pulse`. This is the LONG_T-th tick after entry.
- WAIT2:
  - `press_pulse` -> HOLD2 and emit `dbl_click_pulse`.
  - `sample_ce` with count = DBL_T-1 -> IDLE and emit `click_pulse`.
- HOLD2:
  - `release_pulse` -> IDLE. This state never produces long or repeat events.
- LONG:
  - `sample_ce` with count = REPEAT_T-1 -> emit `repeat_pulse` and clear the count.
  - `release_pulse` -> IDLE with no click.
- Ignored events, state unchanged:
  - `press_pulse` in PRESS1, HOLD2 or LONG.
  - `release_pulse` in IDLE or WAIT2.
- Simultaneous events:
  - `press_pulse` and `release_pulse` both high is a protocol violation. Both are ignored and only the tick (if any) is processed.
  - An event pulse coinciding with `sample_ce` takes priority. The transition happens, the count clears, and that tick is not counted.
- At most one output pulse is produced per clock.

## Timing
- All outputs are registered. Every pulse is exactly 1 clk wide and appears the cycle after the qualifying input cycle.
- `long_active` rises in the same cycle as `long_pulse` and falls the cycle after the terminating `release_pulse`.
- First `repeat_pulse` arrives REPEAT_T ticks after `long_pulse`, then every REPEAT_T ticks.
- Reset (asynchronous, any time, including mid-gesture):
  - State = IDLE, count = 0.
  - All outputs = 0 immediately.
  - No pulse is emitted on reset release.
- Without EN_DOUBLE, click latency is 1 clk after `release_pulse`. With EN_DOUBLE, a single click is reported DBL_T ticks after release.

## Test plan
Bench setup: `CE_HZ`=1000, `LONG_MS`=8, `DBL_MS`=4, `REPEAT_MS`=2, `sample_ce` every 4 clk.

- Press, release after 3 ticks, wait 4 ticks -> exactly one `click_pulse`, on the cycle after the 4th tick; no other pulses; state IDLE.
- Press, release at tick 2, press again at tick 2 of WAIT2, release -> one `dbl_click_pulse` the cycle after the second `press_pulse`; no `click_pulse`.
- Press and hold 13 ticks, then release:
  - `long_pulse` after the 8th tick.
  - `repeat_pulse` after ticks 10 and 12.
  - `long_active` high from `long_pulse` until the cycle after release.
  - No click.
- `EN_DOUBLE`=0, press then release after 1 tick -> `click_pulse` exactly 1 clk after `release_pulse`.
- Boundary cases:
  - `press_pulse` coincident with the 4th `sample_ce` in WAIT2 -> `dbl_click_pulse`, not `click_pulse`.
  - Release coincident with the 8th tick in PRESS1 -> enter WAIT2, no `long_pulse`.
- Assert `rst_n`=0 mid-LONG -> outputs 0 and `long_active` 0 immediately. After release of reset, the next press behaves as from IDLE.
